md_sched: RTL and testbench

Multi-cycle multiply/divide scheduler owning the HI/LO registers. It sits beside the ALU in the execute stage and accepts one-hot MD ops from decode. It runs iterative shift-add multiply and restoring divide, serves mfhi/mflo/mthi/mtlo, and raises a pipeline stall while HI/LO are not yet valid.

---
 rtl/md_sched.sv | 211 +++++++++++++++++++++
 tb/tb_md_sched.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_sched.sv
// md_sched: iterative multiply/divide unit owning HI/LO beside the execute ALU.
// Optional feature macro MD_EARLY_OUT_EN: multiply leaves RUN once remaining multiplier bits are zero.
module md_sched #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             md_valid,
    input  logic [7:0]       md_op,
    input  logic [WIDTH-1:0] md_a,
    input  logic [WIDTH-1:0] md_b,
    input  logic             flush,
    output logic             md_ready,
    output logic             stall,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CW-1:0]      r_cnt;
    logic               r_is_div;
    logic               r_res_neg;
    logic               r_rem_neg;
    logic               r_div0;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_mpl;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_idle;
    logic               w_onehot;
    logic               w_go;
    logic               w_start;
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_last;
    logic               w_fin;
    logic [WIDTH-1:0]   w_mpl_nxt;
    logic [2*WIDTH-1:0] w_prod_nxt;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH:0]     w_sh;
    logic [WIDTH:0]     w_diff;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quot_nxt;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;

    // Malformed op vectors are dropped; flush overrides any new request.
    assign w_idle   = (r_state == S_IDLE);
    assign w_onehot = (md_op != 8'd0) && ((md_op & (md_op - 8'd1)) == 8'd0);
    assign w_go     = md_valid & w_onehot & ~flush;
    assign w_start  = w_idle & w_go & (|md_op[3:0]);

    assign w_signed = md_op[0] | md_op[2];
    assign w_a_neg  = w_signed & md_a[WIDTH-1];
    assign w_b_neg  = w_signed & md_b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? (~md_a + 1'b1) : md_a;
    assign w_b_mag  = w_b_neg ? (~md_b + 1'b1) : md_b;

    assign md_ready = w_idle;
    assign stall    = md_valid & w_onehot & ~w_idle;
    assign busy     = ~w_idle;
    assign rd_valid = w_idle & w_go & (md_op[6] | md_op[7]);
    assign rd_data  = md_op[6] ? r_hi : r_lo;
    assign hi       = r_hi;
    assign lo       = r_lo;

    assign w_mpl_nxt  = r_mpl >> 1;
    assign w_prod_nxt = r_mpl[0] ? (r_prod + r_mcand) : r_prod;

    // Restoring step: shift in next dividend bit, keep difference if non-negative.
    assign w_sh       = {r_rem, r_quot[WIDTH-1]};
    assign w_diff     = w_sh - {1'b0, r_dvs};
    assign w_qbit     = ~w_diff[WIDTH];
    assign w_rem_nxt  = w_qbit ? w_diff[WIDTH-1:0] : w_sh[WIDTH-1:0];
    assign w_quot_nxt = {r_quot[WIDTH-2:0], w_qbit};

    assign w_last = (r_cnt == CW'(WIDTH - 1));

`ifdef MD_EARLY_OUT_EN
    assign w_fin = w_last | (~r_is_div & (w_mpl_nxt == '0));
`else
    assign w_fin = w_last;
`endif

    // Divide by zero yields all-ones quotient; remainder sign-fix restores md_a.
    assign w_prod_fix = r_res_neg ? (~r_prod + 1'b1) : r_prod;
    assign w_q_fix    = r_div0 ? '1
                      : (r_res_neg ? (~r_quot + 1'b1) : r_quot);
    assign w_r_fix    = r_rem_neg ? (~r_rem + 1'b1) : r_rem;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else if (w_fin) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_res_neg <= 1'b0;
            r_rem_neg <= 1'b0;
            r_div0    <= 1'b0;
            r_mcand   <= '0;
            r_prod    <= '0;
            r_mpl     <= '0;
            r_quot    <= '0;
            r_dvs     <= '0;
            r_rem     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_cnt     <= '0;
                        r_is_div  <= md_op[2] | md_op[3];
                        r_res_neg <= w_a_neg ^ w_b_neg;
                        r_rem_neg <= w_a_neg;
                        r_div0    <= (md_b == '0);
                        r_mcand   <= {{WIDTH{1'b0}}, w_a_mag};
                        r_prod    <= '0;
                        r_mpl     <= w_b_mag;
                        r_quot    <= w_a_mag;
                        r_dvs     <= w_b_mag;
                        r_rem     <= '0;
                    end
                    if (w_go & md_op[4]) begin
                        r_hi <= md_a;
                    end
                    if (w_go & md_op[5]) begin
                        r_lo <= md_a;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_is_div) begin
                        r_rem  <= w_rem_nxt;
                        r_quot <= w_quot_nxt;
                    end else begin
                        r_prod  <= w_prod_nxt;
                        r_mcand <= r_mcand << 1;
                        r_mpl   <= w_mpl_nxt;
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        if (r_is_div) begin
                            r_hi <= w_r_fix;
                            r_lo <= w_q_fix;
                        end else begin
                            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed checks of md_sched multiply, divide, HI/LO moves,
// flush, back-to-back issue and asynchronous reset.
module tb_md_sched;

    localparam int W = 32;

    localparam logic [7:0] OP_MULT  = 8'h01;
    localparam logic [7:0] OP_MULTU = 8'h02;
    localparam logic [7:0] OP_DIV   = 8'h04;
    localparam logic [7:0] OP_DIVU  = 8'h08;
    localparam logic [7:0] OP_MTHI  = 8'h10;
    localparam logic [7:0] OP_MTLO  = 8'h20;
    localparam logic [7:0] OP_MFHI  = 8'h40;
    localparam logic [7:0] OP_MFLO  = 8'h80;

`ifdef MD_EARLY_OUT_EN
    localparam int LAT_M3 = 3;
    localparam int LAT_M1 = 2;
    localparam int LAT_M0 = 2;
`else
    localparam int LAT_M3 = W + 1;
    localparam int LAT_M1 = W + 1;
    localparam int LAT_M0 = W + 1;
`endif
    localparam int LAT_DIV = W + 1;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         md_valid = 1'b0;
    logic [7:0]   md_op = 8'h00;
    logic [W-1:0] md_a = '0;
    logic [W-1:0] md_b = '0;
    logic         flush = 1'b0;
    logic         md_ready;
    logic         stall;
    logic [W-1:0] rd_data;
    logic         rd_valid;
    logic         busy;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;

    md_sched #(.WIDTH(W)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .md_valid(md_valid),
        .md_op   (md_op),
        .md_a    (md_a),
        .md_b    (md_b),
        .flush   (flush),
        .md_ready(md_ready),
        .stall   (stall),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic [7:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        md_valid = 1'b1;
        md_op    = op;
        md_a     = a;
        md_b     = b;
        @(posedge clk);
        #1;
        md_valid = 1'b0;
        md_op    = 8'h00;
        md_a     = '0;
        md_b     = '0;
    endtask

    task automatic run_to_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset();
        #2;
        checks++; if (hi !== '0) begin errors++; $display("FAIL reset_hi got %h exp 0", hi); end
        checks++; if (lo !== '0) begin errors++; $display("FAIL reset_lo got %h exp 0", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", md_ready); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
        #10;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        md_valid = 1'b1;
        md_op = OP_MFHI;
        #1;
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL mfhi_valid got %b exp 1", rd_valid); end
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL mfhi_data got %h exp 0", rd_data); end
        md_op = OP_MFLO;
        #1;
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL mflo_valid got %b exp 1", rd_valid); end
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL mflo_data got %h exp 0", rd_data); end
        md_valid = 1'b0;
        md_op = 8'h00;
        issue(8'h03, 32'd5, 32'd5);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL non_onehot_busy got %b exp 0", busy); end
        md_valid = 1'b1;
        md_op = 8'hC0;
        #1;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL non_onehot_rd got %b exp 0", rd_valid); end
        md_valid = 1'b0;
        md_op = 8'h00;
    endtask

    task automatic test_mult();
        int n;
        issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy got %b exp 1", busy); end
        checks++; if (md_ready !== 1'b0) begin errors++; $display("FAIL mult_ready got %b exp 0", md_ready); end
        md_valid = 1'b1;
        md_op = OP_MFLO;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mflo_stall got %b exp 1", stall); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL mflo_busy_rd got %b exp 0", rd_valid); end
        md_valid = 1'b0;
        md_op = 8'h00;
        run_to_idle(n);
        checks++; if (n != LAT_M3) begin errors++; $display("FAIL mult_lat got %0d exp %0d", n, LAT_M3); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h exp ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo got %h exp fffffffa", lo); end
        issue(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
        run_to_idle(n);
        checks++; if (n != LAT_M3) begin errors++; $display("FAIL multu_lat got %0d exp %0d", n, LAT_M3); end
        checks++; if (hi !== 32'h0000_0002) begin errors++; $display("FAIL multu_hi got %h exp 00000002", hi); end
        checks++; if (lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL multu_lo got %h exp fffffffa", lo); end
    endtask

    task automatic test_div();
        int n;
        logic [7:0]   ops [5];
        logic [W-1:0] va  [5];
        logic [W-1:0] vb  [5];
        logic [W-1:0] eh  [5];
        logic [W-1:0] el  [5];
        ops = '{OP_DIV, OP_DIVU, OP_DIV, OP_DIV, OP_DIV};
        va  = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd7, 32'hFFFF_FFF8};
        vb  = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0};
        eh  = '{32'hFFFF_FFFF, 32'd7, 32'd0, 32'd1, 32'hFFFF_FFF8};
        el  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], va[i], vb[i]);
            run_to_idle(n);
            checks++; if (n != LAT_DIV) begin errors++; $display("FAIL div%0d_lat got %0d exp %0d", i, n, LAT_DIV); end
            checks++; if (hi !== eh[i]) begin errors++; $display("FAIL div%0d_hi got %h exp %h", i, hi, eh[i]); end
            checks++; if (lo !== el[i]) begin errors++; $display("FAIL div%0d_lo got %h exp %h", i, lo, el[i]); end
        end
    endtask

    task automatic test_mt_mf();
        int n;
        issue(OP_MTHI, 32'h0000_1234, '0);
        md_valid = 1'b1;
        md_op = OP_MFHI;
        #1;
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL mthi_rd_valid got %b exp 1", rd_valid); end
        checks++; if (rd_data !== 32'h0000_1234) begin errors++; $display("FAIL mthi_rd_data got %h exp 00001234", rd_data); end
        md_valid = 1'b0;
        md_op = 8'h00;
        issue(OP_MTLO, 32'h0000_ABCD, '0);
        checks++; if (lo !== 32'h0000_ABCD) begin errors++; $display("FAIL mtlo_lo got %h exp 0000abcd", lo); end
        issue(OP_MULTU, 32'd2, 32'd3);
        md_valid = 1'b1;
        md_op = OP_MTLO;
        md_a = 32'h0000_5555;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mtlo_busy_stall got %b exp 1", stall); end
        @(posedge clk);
        #1;
        checks++; if (lo !== 32'h0000_ABCD) begin errors++; $display("FAIL mtlo_busy_lo got %h exp 0000abcd", lo); end
        md_valid = 1'b0;
        md_op = 8'h00;
        md_a = '0;
        run_to_idle(n);
        checks++; if (lo !== 32'd6) begin errors++; $display("FAIL mtlo_after_lo got %h exp 00000006", lo); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL mtlo_after_hi got %h exp 00000000", hi); end
    endtask

    task automatic test_flush();
        issue(OP_MTHI, 32'h0000_1111, '0);
        issue(OP_MTLO, 32'h0000_2222, '0);
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b exp 0", busy); end
        checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b exp 1", md_ready); end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checks++; if (hi !== 32'h0000_1111) begin errors++; $display("FAIL flush_hi got %h exp 00001111", hi); end
        checks++; if (lo !== 32'h0000_2222) begin errors++; $display("FAIL flush_lo got %h exp 00002222", lo); end
        flush = 1'b1;
        issue(OP_MULT, 32'd3, 32'd3);
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_back_to_back();
        int n;
        issue(OP_DIVU, 32'd100, 32'd7);
        md_valid = 1'b1;
        md_op = OP_MULTU;
        md_a = 32'd7;
        md_b = 32'd9;
        n = 0;
        while (stall && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (n != W + 1) begin errors++; $display("FAIL b2b_stall got %0d exp %0d", n, W + 1); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL b2b_div_hi got %h exp 00000002", hi); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL b2b_div_lo got %h exp 0000000e", lo); end
        @(posedge clk);
        #1;
        md_valid = 1'b0;
        md_op = 8'h00;
        md_a = '0;
        md_b = '0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got %b exp 1", busy); end
        run_to_idle(n);
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL b2b_mul_hi got %h exp 00000000", hi); end
        checks++; if (lo !== 32'd63) begin errors++; $display("FAIL b2b_mul_lo got %h exp 0000003f", lo); end
    endtask

    task automatic test_early_out();
        int n;
        issue(OP_MULT, 32'd5, 32'd1);
        run_to_idle(n);
        checks++; if (n != LAT_M1) begin errors++; $display("FAIL eo_m1_lat got %0d exp %0d", n, LAT_M1); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL eo_m1_hi got %h exp 00000000", hi); end
        checks++; if (lo !== 32'd5) begin errors++; $display("FAIL eo_m1_lo got %h exp 00000005", lo); end
        issue(OP_MULTU, 32'd9, 32'd0);
        run_to_idle(n);
        checks++; if (n != LAT_M0) begin errors++; $display("FAIL eo_m0_lat got %0d exp %0d", n, LAT_M0); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL eo_m0_lo got %h exp 00000000", lo); end
    endtask

    task automatic test_async_reset();
        issue(OP_MTHI, 32'h0000_DEAD, '0);
        issue(OP_MTLO, 32'h0000_BEEF, '0);
        issue(OP_MULT, 32'd3, 32'd4);
        @(posedge clk);
        #3;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL areset_pre_busy got %b exp 1", busy); end
        resetn = 1'b0;
        #1;
        checks++; if (hi !== '0) begin errors++; $display("FAIL areset_hi got %h exp 0", hi); end
        checks++; if (lo !== '0) begin errors++; $display("FAIL areset_lo got %h exp 0", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %b exp 0", busy); end
        checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL areset_ready got %b exp 1", md_ready); end
        #2;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_post_busy got %b exp 0", busy); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mt_mf();
        test_flush();
        test_back_to_back();
        test_early_out();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
